// File: rtl/seq_cmp_pkg.sv
// seq_cmp_pkg: shared types and helpers for the sequential magnitude comparator
package seq_cmp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/slice_cmp.sv
// slice_cmp: combinational compare of one SLICE-bit slice
// Ports: x, y slice operands; inv_msb flips the top bit of both (two's-complement order);
//        s_eq x==y; s_gt x>y in the selected order.
module slice_cmp #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             inv_msb,
  output logic             s_eq,
  output logic             s_gt
);
  logic [SLICE-1:0] flip;
  assign flip = SLICE'(inv_msb) << (SLICE - 1);
  assign s_eq = x == y;
  assign s_gt = (x ^ flip) > (y ^ flip);
endmodule

// File: rtl/seq_mag_cmp.sv
// seq_mag_cmp: sequential W-bit magnitude comparator, one SLICE-bit slice per cycle, MSB slice first
// Ports: clk, reset_n (async active-low), start, a, b, sgn (only with CMP_SIGNED_EN),
//        busy (compare in progress), done (1-cycle result pulse), eq/gt/lt (held results).
// Option: CMP_SIGNED_EN adds sgn; a latched sgn compares the MSB slice in two's-complement order.
module seq_mag_cmp
  import seq_cmp_pkg::*;
#(
  parameter int W     = 16,
  parameter int SLICE = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef CMP_SIGNED_EN
  input  logic         sgn,
`endif
  output logic         busy,
  output logic         done,
  output logic         eq,
  output logic         gt,
  output logic         lt
);
  localparam int NSL = W / SLICE;
  localparam int IW  = idx_w(NSL);
  localparam logic [IW-1:0] LAST = IW'(NSL - 1);
  cmp_state_t state, state_n;
  cmp_res_t res, res_n;
  logic [W-1:0] ra, rb;
  logic [IW-1:0] idx, idx_n;
  logic busy_n, done_n, accept, sgn_q, s_eq, s_gt;
  int base;
  assign accept = start && state != RUN;
  // slice 0 sits at the top of the operand
  assign base = W - 1 - SLICE * int'(idx);
  slice_cmp #(.SLICE(SLICE)) u_slice (
    .x(ra[base -: SLICE]),
    .y(rb[base -: SLICE]),
    .inv_msb(sgn_q && idx == '0),
    .s_eq(s_eq),
    .s_gt(s_gt)
  );
`ifdef CMP_SIGNED_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sgn_q <= 1'b0;
    else if (accept) sgn_q <= sgn;
`else
  assign sgn_q = 1'b0;
`endif
  always_comb begin
    state_n = state;
    idx_n   = idx;
    res_n   = res;
    busy_n  = busy;
    done_n  = 1'b0;
    if (accept) begin
      state_n = RUN;
      idx_n   = '0;
      res_n   = '0;
      busy_n  = 1'b1;
    end else if (state == RUN) begin
      if (!s_eq || idx == LAST) begin
        state_n = DONE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        res_n   = '{eq: s_eq, gt: !s_eq && s_gt, lt: !s_eq && !s_gt};
      end else idx_n = idx + 1'b1;
    end else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      res   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ra    <= '0;
      rb    <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      res   <= res_n;
      busy  <= busy_n;
      done  <= done_n;
      if (accept) begin
        ra <= a;
        rb <= b;
      end
    end
  assign eq = res.eq;
  assign gt = res.gt;
  assign lt = res.lt;
endmodule
